// File: rtl/prog_counter_if.sv
// Bus bundle for prog_counter: control/data into the counter and registered status out.
interface prog_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable_i;
    logic             load_i;
    logic [WIDTH-1:0] data_i;
    logic             up_i;
    logic [WIDTH-1:0] limit_i;
    logic             clr_ovf_i;
    logic [WIDTH-1:0] count_o;
    logic             tc_o;
    logic             ovf_o;

    modport master (
        output enable_i, load_i, data_i, up_i, limit_i, clr_ovf_i,
        input  count_o, tc_o, ovf_o
    );

    modport slave (
        input  enable_i, load_i, data_i, up_i, limit_i, clr_ovf_i,
        output count_o, tc_o, ovf_o
    );
endinterface

// File: rtl/prog_counter.sv
// Up/down counter with programmable limit, clamped load, wrap or saturate at the
// terminal value, a one-cycle terminal-count pulse and a sticky overflow flag.
module prog_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    prog_counter_if.slave  bus
);
    localparam int unsigned W = WIDTH;

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         ovf_q, ovf_d;
    logic         term_c;

    // Next-state: load beats step beats hold; an out-of-range count snaps to the limit.
    always_comb begin
        count_d = count_q;
        term_c  = 1'b0;
        if (bus.enable_i) begin
            if (bus.load_i) begin
                count_d = (bus.data_i <= bus.limit_i) ? bus.data_i : bus.limit_i;
            end else if (count_q > bus.limit_i) begin
                count_d = bus.limit_i;
            end else if (bus.up_i) begin
                if (count_q == bus.limit_i) begin
                    term_c  = 1'b1;
                    count_d = SATURATE ? bus.limit_i : W'(0);
                end else begin
                    count_d = W'(count_q + W'(1));
                end
            end else begin
                if (count_q == W'(0)) begin
                    term_c  = 1'b1;
                    count_d = SATURATE ? W'(0) : bus.limit_i;
                end else begin
                    count_d = W'(count_q - W'(1));
                end
            end
        end
        tc_d  = term_c;
        // Set wins over a same-cycle clear.
        ovf_d = term_c | (ovf_q & ~bus.clr_ovf_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count_o = count_q;
    assign bus.tc_o    = tc_q;
    assign bus.ovf_o   = ovf_q;
endmodule
